crc_mem_loader: RTL

- Write-side counterpart of crc_fsm.
- Accepts a byte stream over a valid/ready handshake and writes it sequentially into the CRC source memory, from address 0 up to DEPTH-1.
- When the memory is full, pulses crc_start to launch crc_fsm, then waits for crc_rdy before reporting completion.
- Sits between the upstream data source and the shared memory/crc_fsm pair.

---
 rtl/crc_mem_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/crc_mem_loader.sv
// Fills the CRC source memory from a valid/ready byte stream, then kicks crc_fsm
// and waits for its ready flag before reporting completion.
module crc_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk50m,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_we,
  output logic              crc_start,
  input  logic              crc_rdy,
  output logic              load_busy,
  output logic              load_done
);

  // state    | meaning
  // IDLE     | waiting for load_start
  // LOAD     | accepting stream words into memory
  // KICK     | final write in flight, crc_start high
  // WAIT_CRC | waiting for crc_fsm to report ready
  // DONE     | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    KICK     = 3'd2,
    WAIT_CRC = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] LAST_WORD = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_q, we_d;
  logic                start_q, start_d;
  logic                done_q, done_d;

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // abort wins over a same-cycle transfer: that word is dropped
        if (load_abort) begin
          state_d = IDLE;
        end else if (din_valid) begin
          we_d   = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          data_d = din;
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == LAST_WORD) begin
            state_d = KICK;
            start_d = 1'b1;
          end
        end
      end
      // crc_rdy on the edge leaving KICK may be stale, so it is not looked at
      KICK: state_d = WAIT_CRC;
      WAIT_CRC: begin
        if (crc_rdy) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign din_ready    = (state_q == LOAD);
  assign load_busy    = (state_q != IDLE);
  assign mem_addr_out = addr_q;
  assign mem_data_out = data_q;
  assign mem_we       = we_q;
  assign crc_start    = start_q;
  assign load_done    = done_q;

endmodule
